palette_cycler: RTL and testbench

PALETTE_CYCLER -- requirements
Module: palette_cycler

---
 rtl/palette_pkg.sv | 29 ++
 rtl/palette_rot_map.sv | 36 +++
 rtl/palette_cycler.sv | 106 ++++++++++
 tb/tb_palette_cycler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared definitions for the palette cycler.
// - DEFAULT_PALETTE: the demo colors loaded into the table on reset, packed {R,G,B} at 6 bits each.
// - DEF_CH_W: default channel width of the cycler.
// - cfg_ok(): elaboration-time sanity check of the rotation parameters.
package palette_pkg;

  localparam int unsigned DEF_CH_W    = 6;
  localparam int unsigned DEF_ENTRIES = 8;

  typedef logic [3*DEF_CH_W-1:0] rgb18_t;

  localparam rgb18_t DEFAULT_PALETTE [DEF_ENTRIES] = '{
    18'h00000,  // 0 black
    18'h3F000,  // 1 red
    18'h00FC0,  // 2 green
    18'h0003F,  // 3 blue
    18'h3FFC0,  // 4 yellow
    18'h00FFF,  // 5 cyan
    18'h3F03F,  // 6 magenta
    18'h20820   // 7 mid gray
  };

  // True when the rotating range is non-empty, fits in the table, and the divider is usable.
  function automatic bit cfg_ok(int unsigned idx_w, int unsigned lo, int unsigned hi,
                                int unsigned div);
    return (idx_w >= 1) && (idx_w < 31) && (hi > lo) && (hi < (32'd1 << idx_w)) && (div >= 1);
  endfunction

endpackage

// File: rtl/palette_rot_map.sv
// Combinational color-index rotation.
// - color   : physical pixel index
// - offset  : current rotation amount, 0..SPAN-1
// - eff_idx : table entry to read; indices outside [CYC_LO, CYC_HI] pass through unchanged
module palette_rot_map import palette_pkg::*; #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned CYC_LO = 1,
  parameter int unsigned CYC_HI = 7
) (
  input  logic [IDX_W-1:0] color,
  input  logic [IDX_W-1:0] offset,
  output logic [IDX_W-1:0] eff_idx
);

  localparam int unsigned            W1     = IDX_W + 1;
  localparam logic [IDX_W-1:0]       LO_I   = IDX_W'(CYC_LO);
  localparam logic [IDX_W:0]         SPAN_I = W1'(CYC_HI - CYC_LO + 1);

  logic [IDX_W-1:0] rel;
  logic [IDX_W:0]   sum;

  always_comb begin
    // A color below CYC_LO wraps rel to a value >= SPAN, so one compare covers both bounds.
    rel = color - LO_I;
    sum = {1'b0, rel} + {1'b0, offset};
    // Both operands are < SPAN, so a single subtraction completes the modulo.
    if (sum >= SPAN_I) begin
      sum = sum - SPAN_I;
    end
    eff_idx = color;
    if ({1'b0, rel} < SPAN_I) begin
      eff_idx = LO_I + sum[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/palette_cycler.sv
// Palette lookup with color cycling.
// - clk, rst_n        : clock, asynchronous active-low reset
// - color, pix_en     : pixel index and active-area flag; r/g/b follow one cycle later
// - frame_tick, cyc_en: per-frame pulse and rotation enable; offset steps every CYC_DIV ticks
// - wr_*              : entry-write handshake, ready only during blanking
// - r, g, b           : registered color outputs, zero outside the active area
module palette_cycler import palette_pkg::*; #(
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned CH_W    = DEF_CH_W,
  parameter int unsigned CYC_LO  = 1,
  parameter int unsigned CYC_HI  = 7,
  parameter int unsigned CYC_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  color,
  input  logic              pix_en,
  input  logic              frame_tick,
  input  logic              cyc_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b
);

  localparam int unsigned      NUM      = 2 ** IDX_W;
  localparam int unsigned      RGB_W    = 3 * CH_W;
  localparam int unsigned      SPAN     = CYC_HI - CYC_LO + 1;
  localparam int unsigned      DIV_W    = (CYC_DIV > 1) ? $clog2(CYC_DIV) : 1;
  localparam logic [IDX_W-1:0] OFF_LAST = IDX_W'(SPAN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYC_DIV - 1);

  if (!cfg_ok(IDX_W, CYC_LO, CYC_HI, CYC_DIV)) begin : g_cfg_err
    $error("palette_cycler: need CYC_LO < CYC_HI < 2**IDX_W and CYC_DIV >= 1");
  end

  // Default entries are resized per channel; entries past the demo set reset to black.
  function automatic logic [RGB_W-1:0] reset_entry(int unsigned i);
    rgb18_t e;
    e = (i < DEF_ENTRIES) ? DEFAULT_PALETTE[i[2:0]] : '0;
    return {CH_W'(e[17:12]), CH_W'(e[11:6]), CH_W'(e[5:0])};
  endfunction

  logic [RGB_W-1:0] pal_q [NUM];
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [IDX_W-1:0] off_q, off_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] eff_idx;

  assign wr_ready = !pix_en;

  palette_rot_map #(
    .IDX_W  (IDX_W),
    .CYC_LO (CYC_LO),
    .CYC_HI (CYC_HI)
  ) u_rot_map (
    .color   (color),
    .offset  (off_q),
    .eff_idx (eff_idx)
  );

  always_comb begin
    div_d = div_q;
    off_d = off_q;
    if (cyc_en && frame_tick) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        off_d = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    rgb_d = pix_en ? pal_q[eff_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      off_q <= '0;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      off_q <= off_d;
      rgb_q <= rgb_d;
    end
  end

  // Writes use the physical index; rotation only affects reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        pal_q[i] <= reset_entry(i);
      end
    end else if (wr_valid && wr_ready) begin
      pal_q[wr_idx] <= wr_rgb;
    end
  end

  assign r = rgb_q[3*CH_W-1:2*CH_W];
  assign g = rgb_q[2*CH_W-1:CH_W];
  assign b = rgb_q[CH_W-1:0];

endmodule

// File: tb/tb_palette_cycler.sv
// Directed bench for palette_cycler with default parameters.
module tb_palette_cycler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  color;
  logic        pix_en;
  logic        frame_tick;
  logic        cyc_en;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_idx;
  logic [17:0] wr_rgb;
  logic [5:0]  r, g, b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  palette_cycler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .color      (color),
    .pix_en     (pix_en),
    .frame_tick (frame_tick),
    .cyc_en     (cyc_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_rgb     (wr_rgb),
    .r          (r),
    .g          (g),
    .b          (b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic look(input logic [2:0] c, input string tag, input logic [17:0] exp);
    pix_en = 1'b1;
    color  = c;
    step();
    check_eq(tag, {14'd0, r, g, b}, {14'd0, exp});
    pix_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    color      = 3'd3;
    pix_en     = 1'b1;
    frame_tick = 1'b0;
    cyc_en     = 1'b0;
    wr_valid   = 1'b0;
    wr_idx     = '0;
    wr_rgb     = '0;

    // Reset
    step();
    step();
    check_eq("rst_rgb_zero", {14'd0, r, g, b}, 32'h0);
    check_eq("rst_wr_ready_active", {31'd0, wr_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_entry3", {14'd0, r, g, b}, 32'h0003F);
    pix_en = 1'b0;
    step();
    check_eq("pix_off_zero", {14'd0, r, g, b}, 32'h0);
    check_eq("wr_ready_blank", {31'd0, wr_ready}, 32'd1);

    // Rotation
    look(3'd7, "rot0_c7", 18'h20820);
    look(3'd1, "rot0_c1", 18'h3F000);
    cyc_en = 1'b1;
    tick(3);
    look(3'd1, "rot_3ticks_c1", 18'h3F000);
    tick(1);
    look(3'd7, "rot1_c7", 18'h3F000);
    look(3'd0, "rot1_c0", 18'h00000);
    look(3'd1, "rot1_c1", 18'h00FC0);
    tick(23);
    look(3'd1, "rot6_c1", 18'h20820);
    tick(1);
    look(3'd1, "rot_wrap_c1", 18'h3F000);
    cyc_en = 1'b0;

    // Write handshake, blocked while pixels are active
    pix_en   = 1'b1;
    color    = 3'd2;
    wr_valid = 1'b1;
    wr_idx   = 3'd2;
    wr_rgb   = 18'h3FFFF;
    #1;
    check_eq("wr_ready_low", {31'd0, wr_ready}, 32'd0);
    step();
    check_eq("wr_blocked_1", {14'd0, r, g, b}, 32'h00FC0);
    step();
    check_eq("wr_blocked_2", {14'd0, r, g, b}, 32'h00FC0);
    pix_en = 1'b0;
    #1;
    check_eq("wr_ready_high", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0;
    look(3'd2, "wr_accepted", 18'h3FFFF);
    look(3'd0, "wr_other_intact", 18'h00000);

    // Write coincident with the offset step
    cyc_en = 1'b1;
    tick(3);
    wr_valid = 1'b1;
    wr_idx   = 3'd5;
    wr_rgb   = 18'h12345;
    tick(1);
    wr_valid = 1'b0;
    look(3'd4, "sim_entry5_rot", 18'h12345);
    look(3'd5, "sim_offset1", 18'h3F03F);
    cyc_en = 1'b0;

    // cyc_en hold: offset 1, divider 0
    cyc_en = 1'b1;
    tick(2);
    cyc_en = 1'b0;
    tick(5);
    look(3'd1, "hold_after_off", 18'h3FFFF);
    cyc_en = 1'b1;
    tick(1);
    look(3'd1, "hold_8th_tick", 18'h3FFFF);
    tick(1);
    look(3'd1, "hold_step", 18'h0003F);
    cyc_en = 1'b0;

    // Reset landing on an accepted write
    wr_valid = 1'b1;
    wr_idx   = 3'd2;
    wr_rgb   = 18'h0ABCD;
    #2;
    rst_n = 1'b0;
    step();
    wr_valid = 1'b0;
    check_eq("rst_mid_rgb", {14'd0, r, g, b}, 32'h0);
    rst_n = 1'b1;
    step();
    look(3'd2, "rst_mid_entry2", 18'h00FC0);
    look(3'd1, "rst_mid_offset0", 18'h3F000);
    look(3'd5, "rst_mid_entry5", 18'h00FFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
